// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU scheduler.
// Opcodes, scheduler states, flag positions and latency lookup.
package alu_ctrl_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_MUL  = 3'b100;
    localparam logic [2:0] ALU_DIV  = 3'b101;
    localparam logic [2:0] ALU_NOT  = 3'b110;
    localparam logic [2:0] ALU_PASS = 3'b111;

    localparam int FLAG_N   = 31;
    localparam int FLAG_Z   = 30;
    localparam int FLAG_INV = 29;
    localparam int FLAG_V   = 28;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } sched_state_t;

    // Multiply and divide take the long path; everything else is simple.
    function automatic logic [3:0] op_latency(
        input logic [2:0] op,
        input int         muldiv_cycles,
        input int         simple_cycles
    );
        if (op == ALU_MUL || op == ALU_DIV)
            return 4'(muldiv_cycles);
        return 4'(simple_cycles);
    endfunction

endpackage

// File: rtl/alu_scheduler_rr_arb.sv
// Two-way grant for the shared ALU.
// Purely combinational; the priority register lives in the parent.
import alu_ctrl_pkg::*;

module alu_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant
);

    // A lone requester wins; on contention prio names the winner.
    always_comb begin
        grant = 2'b00;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one external combinational ALU between two requesters.
// Holds operands for a per-opcode latency and returns a registered result.
import alu_ctrl_pkg::*;

module alu_scheduler #(
    parameter int MULDIV_CYCLES = 4,
    parameter int SIMPLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_op,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic [31:0] rsp0_flags,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic [31:0] rsp1_flags,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_out,
    input  logic [31:0] alu_flags,
    output logic        busy
);

    sched_state_t state;
    logic         prio;
    logic         owner;
    logic [3:0]   cnt;
    logic [31:0]  a_q;
    logic [31:0]  b_q;
    logic [2:0]   op_q;
    logic [31:0]  res_q;
    logic [31:0]  flg_q;
    logic [1:0]   rsp_v;
    logic [1:0]   grant;
    logic [1:0]   accept;
    logic [31:0]  in_a;
    logic [31:0]  in_b;
    logic [2:0]   in_op;
    logic [31:0]  flags_cap;
    logic         unused_flags;

    alu_rr_arb2 u_arb (
        .valid ({req1_valid, req0_valid}),
        .prio  (prio),
        .grant (grant)
    );

    assign accept     = (state == S_IDLE) ? grant : 2'b00;
    assign req0_ready = accept[0];
    assign req1_ready = accept[1];

    assign in_a  = accept[1] ? req1_a  : req0_a;
    assign in_b  = accept[1] ? req1_b  : req0_b;
    assign in_op = accept[1] ? req1_op : req0_op;

    // Only the four architectural flag bits are kept.
    assign flags_cap    = {alu_flags[31:28], 28'd0};
    assign unused_flags = ^alu_flags[27:0];

    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign alu_op = op_q;

    assign rsp0_valid  = rsp_v[0];
    assign rsp1_valid  = rsp_v[1];
    assign rsp0_result = res_q;
    assign rsp1_result = res_q;
    assign rsp0_flags  = flg_q;
    assign rsp1_flags  = flg_q;

    assign busy = (state != S_IDLE);

    // Accept, hold operands for the op latency, then hand back the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            prio  <= 1'b0;
            owner <= 1'b0;
            cnt   <= 4'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            op_q  <= ALU_ADD;
            res_q <= 32'd0;
            flg_q <= 32'd0;
            rsp_v <= 2'b00;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (|accept) begin
                        owner <= accept[1];
                        a_q   <= in_a;
                        b_q   <= in_b;
                        op_q  <= in_op;
                        cnt   <= op_latency(in_op, MULDIV_CYCLES,
                                            SIMPLE_CYCLES) - 4'd1;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cnt == 4'd0) begin
                        res_q <= alu_out;
                        flg_q <= flags_cap;
                        rsp_v <= owner ? 2'b10 : 2'b01;
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if ((rsp_v & {rsp1_ready, rsp0_ready}) != 2'b00) begin
                        rsp_v <= 2'b00;
                        prio  <= ~owner;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_scheduler.sv
// Scoreboard bench for alu_scheduler with an external ALU model.
// Directed cases from the test plan followed by randomized traffic.
import alu_ctrl_pkg::*;

module tb_alu_scheduler;

    localparam int MD = 4;
    localparam int SC = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp0_result, rsp0_flags, rsp1_result, rsp1_flags;
    logic [31:0] alu_a, alu_b, alu_out, alu_flags;
    logic [2:0]  alu_op;
    logic        busy;

    always #5 clk = ~clk;

    alu_scheduler #(.MULDIV_CYCLES(MD), .SIMPLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_flags(alu_flags), .busy(busy)
    );

    // Architectural ALU: returns {flags, result}.
    function automatic logic [63:0] ref_alu(
        input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        longint sa, sb, w;
        logic [31:0] r;
        logic inv, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        w = 0;
        inv = 1'b0;
        case (op)
            3'd0: w = sa + sb;
            3'd1: w = sa - sb;
            3'd2: w = longint'($signed(a & b));
            3'd3: w = longint'($signed(a | b));
            3'd4: w = sa * sb;
            3'd5: if (sb == 0) inv = 1'b1; else w = sa / sb;
            3'd6: w = longint'($signed(~a));
            default: w = sa;
        endcase
        r = w[31:0];
        v = (w > 64'sd2147483647) || (w < -64'sd2147483648);
        return {r[31], (r == 32'd0), inv, v, 28'd0, r};
    endfunction

    logic [63:0] alu_ref;
    logic [27:0] junk = 28'd0;
    assign alu_ref   = ref_alu(alu_a, alu_b, alu_op);
    assign alu_out   = alu_ref[31:0];
    assign alu_flags = {alu_ref[63:60], junk};
    always @(posedge clk) junk <= 28'($urandom);

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        logic        port;
        logic [31:0] a, b, res, flg;
        logic [2:0]  op;
        int          due;
    } exp_t;

    typedef struct {
        logic [31:0] a, b;
        logic [2:0]  op;
    } req_t;

    exp_t sbq[$];
    exp_t cur;
    exp_t infl;
    bit   have_cur = 0;
    bit   expect_idle = 0;
    bit   model_prio = 0;
    int   acc_n[2] = '{0, 0};
    int   checks = 0;
    int   errors = 0;

    logic [1:0]  mv, mr, mwant, rv, rr;
    logic        mp;
    logic [31:0] mres, mflg;
    exp_t        ne;

    // Monitor: grant model, scoreboard push/pop and hold checks.
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            have_cur = 0;
            expect_idle = 0;
            model_prio = 0;
            checks++;
            if ({rsp0_valid, rsp1_valid, busy, req0_ready, req1_ready} !== 5'b0
                || rsp0_result !== 32'd0 || rsp1_result !== 32'd0
                || rsp0_flags !== 32'd0 || rsp1_flags !== 32'd0
                || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 3'd0) begin
                errors++;
                $display("FAIL reset: rv=%b%b busy=%b res=%h flg=%h alu=%h/%h/%0d",
                         rsp1_valid, rsp0_valid, busy, rsp0_result,
                         rsp0_flags, alu_a, alu_b, alu_op);
            end
        end else begin
            rv = {rsp1_valid, rsp0_valid};
            rr = {rsp1_ready, rsp0_ready};
            if (expect_idle) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_after_xfer: busy=%b need 0", busy);
                end
                expect_idle = 0;
            end
            if (rv == 2'b11) begin
                checks++;
                errors++;
                $display("FAIL rsp_both: rsp_valid=%b need one-hot", rv);
            end else if (rv != 2'b00) begin
                mp = rv[1];
                if (!have_cur) begin
                    checks++;
                    if (sbq.size() == 0) begin
                        errors++;
                        $display("FAIL rsp_unexpected: port %0d valid, none pending", mp);
                    end else begin
                        cur = sbq.pop_front();
                        have_cur = 1;
                        if (edge_n != cur.due) begin
                            errors++;
                            $display("FAIL latency: rsp at cycle %0d need %0d (op %0d)",
                                     edge_n, cur.due, cur.op);
                        end
                    end
                end
                if (have_cur) begin
                    mres = mp ? rsp1_result : rsp0_result;
                    mflg = mp ? rsp1_flags : rsp0_flags;
                    checks++;
                    if (mp !== cur.port || mres !== cur.res || mflg !== cur.flg) begin
                        errors++;
                        $display("FAIL rsp: port %0d res %h flg %h, need port %0d res %h flg %h (a=%h b=%h op=%0d)",
                                 mp, mres, mflg, cur.port, cur.res, cur.flg,
                                 cur.a, cur.b, cur.op);
                    end
                    if (rr[mp]) begin
                        have_cur = 0;
                        expect_idle = 1;
                        model_prio = ~mp;
                    end
                end
            end
            mv = {req1_valid, req0_valid};
            mr = {req1_ready, req0_ready};
            if (busy) begin
                checks++;
                if (mr !== 2'b00 || alu_a !== infl.a || alu_b !== infl.b
                    || alu_op !== infl.op) begin
                    errors++;
                    $display("FAIL hold: ready=%b alu=%h/%h/%0d need 00 %h/%h/%0d",
                             mr, alu_a, alu_b, alu_op, infl.a, infl.b, infl.op);
                end
            end else if (mv != 2'b00) begin
                mwant = (mv == 2'b11) ? (model_prio ? 2'b10 : 2'b01) : mv;
                checks++;
                if (mr !== mwant) begin
                    errors++;
                    $display("FAIL grant: ready=%b need %b (valid=%b)", mr, mwant, mv);
                end
                for (int i = 0; i < 2; i++) begin
                    if (mr[i] && mv[i]) begin
                        ne.port = i[0];
                        ne.a    = i ? req1_a : req0_a;
                        ne.b    = i ? req1_b : req0_b;
                        ne.op   = i ? req1_op : req0_op;
                        {ne.flg, ne.res} = ref_alu(ne.a, ne.b, ne.op);
                        ne.due  = edge_n + 1 +
                                  ((ne.op == 3'd4 || ne.op == 3'd5) ? MD : SC);
                        sbq.push_back(ne);
                        infl = ne;
                        acc_n[i]++;
                    end
                end
            end
        end
    end

    req_t q0[$];
    req_t q1[$];
    int   seen0 = 0;
    int   seen1 = 0;
    bit   rnd = 0;
    bit   hold0 = 0;

    task automatic push(input int p, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] op);
        req_t r;
        r.a = a;
        r.b = b;
        r.op = op;
        if (p == 0) q0.push_back(r);
        else q1.push_back(r);
    endtask

    // One cycle of driving: present queue heads, then consume accepts.
    task automatic step();
        req0_valid = (q0.size() > 0) && !(rnd && $urandom_range(0, 7) == 0);
        req1_valid = (q1.size() > 0) && !(rnd && $urandom_range(0, 7) == 0);
        if (q0.size() > 0) begin
            req0_a = q0[0].a; req0_b = q0[0].b; req0_op = q0[0].op;
        end
        if (q1.size() > 0) begin
            req1_a = q1[0].a; req1_b = q1[0].b; req1_op = q1[0].op;
        end
        if (rnd) begin
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
        end else begin
            rsp0_ready = !hold0;
            rsp1_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        if (acc_n[0] != seen0) begin seen0 = acc_n[0]; q0.delete(0); end
        if (acc_n[1] != seen1) begin seen1 = acc_n[1]; q1.delete(0); end
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || sbq.size() > 0
                || have_cur || busy) && n < bound) begin
            step();
            n++;
        end
        if (n >= bound) begin
            $display("FAIL drain_timeout: q0=%0d q1=%0d pending=%0d busy=%b",
                     q0.size(), q1.size(), sbq.size(), busy);
            $fatal(1, "bench stopped on timeout");
        end
    endtask

    task automatic wait_cond(input bit which, input int bound);
        int n;
        n = 0;
        while (((which == 0) ? (q0.size() > 0) : !rsp0_valid) && n < bound) begin
            step();
            n++;
        end
        if (n >= bound) begin
            $display("FAIL wait_timeout: stage %0d", which);
            $fatal(1, "bench stopped on timeout");
        end
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_op = 0;
        req1_a = 0; req1_b = 0; req1_op = 0;
        rsp0_ready = 1; rsp1_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        push(0, 32'd5, 32'd7, ALU_ADD);
        drain(100);

        do_reset();
        push(0, 32'd3, 32'd5, ALU_SUB);
        push(1, 32'hF0, 32'h0F, ALU_OR);
        push(0, 32'd100, 32'hFFFF_FFFF, ALU_ADD);
        drain(100);

        push(0, 32'h1_0000, 32'h1_0000, ALU_MUL);
        drain(100);
        push(1, 32'd10, 32'd0, ALU_DIV);
        drain(100);
        push(1, 32'h7FFF_FFFF, 32'd1, ALU_ADD);
        push(0, 32'h1234, 32'd0, ALU_PASS);
        drain(100);

        hold0 = 1;
        push(0, 32'd100, 32'd23, ALU_ADD);
        wait_cond(0, 50);
        push(1, 32'd9, 32'd4, ALU_SUB);
        wait_cond(1, 50);
        repeat (3) step();
        hold0 = 0;
        drain(100);

        push(0, 32'h1_0000, 32'h1_0000, ALU_MUL);
        wait_cond(0, 50);
        step();
        do_reset();
        push(0, 32'd1, 32'd2, ALU_ADD);
        drain(100);

        rnd = 1;
        for (int i = 0; i < 300; i++)
            push($urandom_range(0, 1), pick(), pick(), 3'($urandom_range(0, 7)));
        drain(20000);
        rnd = 0;
        drain(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

- Shares one combinational ALU instance between two requesters: execute-stage port 0 and auxiliary/coprocessor port 1.
- Each requester offers one operation through a valid/ready handshake; a round-robin pointer picks the winner when both request.
- Operands and opcode are held stable at the ALU for a per-opcode number of cycles, which gives multiply/divide a multicycle path.
- Result and flags are registered and returned to the owning requester through a response valid/ready handshake.

## Interface
- `MULDIV_CYCLES`, default 4: EXEC cycles for opcodes 3'b100 and 3'b101, legal range 1..15.
- `SIMPLE_CYCLES`, default 1: EXEC cycles for all other opcodes, legal range 1..15.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  request offered.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  32  signed operands.
- `req0_op` / `req1_op`  in  3  ALU opcode.
- `rsp0_valid` / `rsp1_valid`  out  1  response available.
- `rsp0_ready` / `rsp1_ready`  in  1  requester takes the response.
- `rsp0_result` / `rsp1_result`  out  32  registered ALU result.
- `rsp0_flags` / `rsp1_flags`  out  32  registered flags: bit 31 N, bit 30 Z, bit 29 invalid, bit 28 V, all other bits 0.
- `alu_a`, `alu_b`  out  32  operands driven to the ALU.
- `alu_op`  out  3  opcode driven to the ALU.
- `alu_out`  in  32  ALU result.
- `alu_flags`  in  32  ALU flags.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- States:
  - IDLE: no operation in flight.
  - EXEC: operands held at the ALU, cycle counter running.
  - RESP: result registered, waiting for the owner to take it.
- IDLE:
  - `reqN_ready` = IDLE & `reqN_valid` & grant(N); combinational.
  - Grant rule: if only one requester is valid, it wins; if both are valid, the requester named by `prio` wins.
  - On acceptance: latch a, b, op and owner; load `cnt` = latency(op) − 1; go to EXEC.
- EXEC:
  - `alu_a`/`alu_b`/`alu_op` come from the latched registers and stay constant for the whole state.
  - `cnt` decrements each cycle.
  - In the cycle with `cnt`==0: capture `alu_out` and `alu_flags` (bits 31:28 only, rest zeroed) into the result registers; go to RESP.
- RESP:
  - `rsp<owner>_valid` = 1; the other `rspN_valid` = 0.
  - `rsp<owner>_ready` = 1 completes the transfer: go to IDLE, set `prio` = ~owner.
  - Result and flags hold until the transfer completes.
- No new request is accepted outside IDLE: both `reqN_ready` = 0 in EXEC and RESP.
- Flag and result values pass through unchanged; the scheduler does not reinterpret them. Example: divide by zero returns result 0 with flags 29 and 30 set.
- Opcode 3'b111 is scheduled as a simple op.
- `rspN_result`/`rspN_flags` may show the last captured value on both ports; only `rspN_valid` qualifies them.

## Timing
- Reset values:
  - State IDLE, `prio` = 0, `cnt` = 0.
  - All `rspN_valid` = 0, results and flags = 0.
  - `alu_a` = `alu_b` = 0, `alu_op` = 3'b000, `busy` = 0.
- Reset mid-operation: the in-flight op is discarded and no response is produced.
- Acceptance edge T0 (valid & ready high):
  - EXEC occupies cycles T0+1 .. T0+L, where L = latency(op).
  - Capture happens at the edge ending cycle T0+L.
  - `rspN_valid` is high from cycle T0+L+1.
- Example: add with `SIMPLE_CYCLES`=1 gives `rsp_valid` 2 cycles after acceptance.
- If the response is taken on the first RESP cycle, IDLE follows, so the next acceptance is at the earliest L+2 cycles after the previous one.
- `req*_valid` dropping while not granted is legal; there is no obligation to hold it.

## Structure
- Package `alu_ctrl_pkg` holds:
  - Opcode constants `ALU_ADD`..`ALU_NOT`, `ALU_PASS`.
  - State enum `sched_state_t`.
  - Flag index constants `FLAG_N`=31, `FLAG_Z`=30, `FLAG_INV`=29, `FLAG_V`=28.
  - Function `op_latency(op)`.
- Sub-module `alu_rr_arb2`: combinational two-way grant from `valid[1:0]` and `prio`. The `prio` register update stays in the top module.
- The ALU itself is instantiated by the parent datapath and connects through the `alu_*` ports.

## Test plan
- Add on req0: a=5, b=7, op=000 → `req0_ready` high at accept; `rsp0_valid` from T0+2; result 12; flags 0.
- Simultaneous requests after reset:
  - Stimulus: req0 sub 3−5 and req1 or 0xF0|0x0F, both valid.
  - Required response: req0 served first with 0xFFFFFFFE and flag 31 set; req1 served next with 0xFF and flags 0.
  - Then, with both valid again, req1 is served first.
- Multiply 0x10000×0x10000 with `MULDIV_CYCLES`=4 → `alu_a`/`alu_b`/`alu_op` stable for 4 cycles; `rsp_valid` at T0+5; result 0; flags 30 and 28 set.
- Divide 10/0 on req1 → result 0; flags 29 and 30 set; `rsp1_valid` only.
- Backpressure: `rsp0_ready` low for 3 RESP cycles while `req1_valid`=1 → result held constant; `req1_ready` stays 0; req1 is accepted the cycle after the transfer completes.
- `rst_n` pulsed low mid-EXEC of a multiply → all outputs 0 immediately; no response; the next req0 add completes normally.
